// File: rtl/mb32_dot_acc.sv
// mb32_dot_acc: dot-product accumulator downstream of the mb32_top Booth multiplier.
// Aligns valid/last tags with the multiplier latency, accumulates unsigned products
// per vector, and queues finished sums in a 2-entry FIFO with credit-based in_ready.
module mb32_dot_acc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 3,
    parameter int unsigned ACC_W = 80,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    localparam int unsigned CRW = $clog2(LAT + 3) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } entry_t;

    // Tag pipeline: stage LAT-1 is the tap aligned with product
    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_last;
    logic           acc_in;
    logic           t_valid;
    logic           t_last;

    // Accumulator state
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // Datapath for the term currently at the tap
    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_full;
    logic             cnt_sat;
    logic [CNT_W-1:0] next_cnt;
    logic             next_ovf;
    entry_t           push_entry;

    // FIFO state
    entry_t     head;
    entry_t     tail;
    logic [1:0] fifo_cnt;
    logic       push;
    logic       pop;

    // Credit accounting
    logic [CRW-1:0] inflight;

    assign acc_in  = in_valid & in_ready;
    assign t_valid = tag_valid[LAT-1];
    assign t_last  = tag_last[LAT-1];

    // Shift {accepted, last} tags alongside the multiplier pipeline
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= acc_in;
            tag_last[0]  <= acc_in & in_last;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    // Count vector-ending tags still travelling toward the FIFO
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight = inflight + CRW'(tag_last[i]);
        end
    end

    assign in_ready = (CRW'(fifo_cnt) + inflight) < CRW'(2);

    // IDLE behaves as ACCUM starting from a zero accumulator, so both states
    // share one adder; a first term can never carry since ACC_W >= 2*WIDTH.
    always_comb begin
        base_acc = (state == ACCUM) ? acc : '0;
        base_cnt = (state == ACCUM) ? cnt : '0;
        base_ovf = (state == ACCUM) ? ovf : 1'b0;
        prod_ext = {{(ACC_W + 1 - 2*WIDTH){1'b0}}, product};
        sum_full = {1'b0, base_acc} + prod_ext;
        cnt_sat  = (base_cnt == '1);
        next_cnt = cnt_sat ? base_cnt : base_cnt + CNT_W'(1);
        next_ovf = base_ovf | sum_full[ACC_W] | cnt_sat;
        push_entry.sum   = sum_full[ACC_W-1:0];
        push_entry.count = next_cnt;
        push_entry.ovf   = next_ovf;
    end

    assign push = t_valid & t_last;
    assign pop  = out_valid & out_ready;

    // Accumulator FSM: fold each tapped term in, close the vector on its last term
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (t_valid) begin
            if (t_last) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else begin
                state <= ACCUM;
                acc   <= push_entry.sum;
                cnt   <= push_entry.count;
                ovf   <= push_entry.ovf;
            end
        end
    end

    // Two-entry FIFO; head register drives the outputs directly
    always_ff @(posedge CLK) begin
        if (!RST) begin
            fifo_cnt <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        head <= push_entry;
                    end else begin
                        tail <= push_entry;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    head     <= tail;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        head <= push_entry;
                    end else begin
                        head <= tail;
                        tail <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_sum   = head.sum;
    assign out_count = head.count;
    assign out_ovf   = head.ovf;

    // Credit scheme guarantees a push never meets a full FIFO
    a_no_fifo_overflow: assert property (@(posedge CLK) disable iff (!RST)
        !(push && !pop && fifo_cnt == 2'd2));

endmodule

// File: tb/tb_mb32_dot_acc.sv
// Self-checking bench for mb32_dot_acc: models the multiplier latency and keeps
// a scoreboard of expected vector results for an 80-bit and a 64-bit accumulator.
module tb_mb32_dot_acc;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] mx = '0;
    logic [31:0] my = '0;
    logic [63:0] pp [LAT];
    logic [63:0] product;

    logic        in_ready, out_valid, out_ovf;
    logic [79:0] out_sum;
    logic [15:0] out_count;
    logic        in_ready64, out_valid64, out_ovf64;
    logic [63:0] out_sum64;
    logic [15:0] out_count64;

    int checks = 0;
    int errors = 0;

    logic [96:0] q80[$];
    logic [80:0] q64[$];
    logic [96:0] exp80;
    logic [80:0] exp64;

    logic [79:0] m80;
    logic [63:0] m64;
    logic        ovf80, ovf64;
    logic [15:0] mcnt;

    always #5 clk = ~clk;

    // Behavioural multiplier: product of operands issued LAT cycles earlier
    always @(posedge clk) begin
        pp[0] <= 64'(mx) * 64'(my);
        for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
    assign product = pp[LAT-1];

    mb32_dot_acc #(.WIDTH(32), .LAT(LAT), .ACC_W(80), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .product(product), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    mb32_dot_acc #(.WIDTH(32), .LAT(LAT), .ACC_W(64), .CNT_W(16)) dut64 (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready64), .product(product), .out_valid(out_valid64),
        .out_ready(out_ready), .out_sum(out_sum64), .out_count(out_count64),
        .out_ovf(out_ovf64)
    );

    task automatic model_clear();
        m80 = '0; m64 = '0; ovf80 = 1'b0; ovf64 = 1'b0; mcnt = '0;
    endtask

    // Drive one term for one cycle; update scoreboard if the DUT can take it
    task automatic drive(input logic last, input logic [31:0] a, input logic [31:0] b,
                         output logic taken);
        logic [63:0] p;
        logic [80:0] t80;
        logic [64:0] t64;
        in_valid = 1'b1; in_last = last; mx = a; my = b;
        taken = in_ready;
        if (taken) begin
            p   = 64'(a) * 64'(b);
            t80 = {1'b0, m80} + 81'(p);
            t64 = {1'b0, m64} + 65'(p);
            if (t80[80]) ovf80 = 1'b1;
            if (t64[64]) ovf64 = 1'b1;
            m80 = t80[79:0];
            m64 = t64[63:0];
            if (mcnt == 16'hFFFF) begin
                ovf80 = 1'b1; ovf64 = 1'b1;
            end else begin
                mcnt = mcnt + 16'd1;
            end
            if (last) begin
                q80.push_back({m80, mcnt, ovf80});
                q64.push_back({m64, mcnt, ovf64});
                model_clear();
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_result(input string name, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: out_valid timeout, got 0 required 1", name);
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; mx = 32'd1; my = 32'd1; out_ready = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if ({out_sum, out_count, out_ovf} !== 97'd0) begin errors++; $display("FAIL reset_head: got %h required 0", {out_sum, out_count, out_ovf}); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || out_valid64) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_result: got %b required 0", seen); end
    endtask

    task automatic test_single();
        logic taken;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b required 1", in_ready); end
        drive(1'b1, 32'd7, 32'd6, taken);
        for (int k = 1; k <= LAT + 2; k++) begin
            checks++;
            if (out_valid !== (k == LAT + 1)) begin
                errors++; $display("FAIL single_valid_cycle%0d: got %b required %b", k, out_valid, (k == LAT + 1));
            end
            if (k == LAT + 1) begin
                exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
                exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
                checks++; if ({out_sum, out_count, out_ovf} !== exp80) begin errors++; $display("FAIL single_result: got %h required %h", {out_sum, out_count, out_ovf}, exp80); end
                checks++; if ({out_sum, out_count, out_ovf} !== {80'd42, 16'd1, 1'b0}) begin errors++; $display("FAIL single_const: got %h required sum 42 count 1", {out_sum, out_count, out_ovf}); end
                checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL single_result64: got %h required %h", {out_sum64, out_count64, out_ovf64}, exp64); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gap_vector();
        logic taken, ok;
        drive(1'b0, 32'd3, 32'd4, taken);
        idle(1);
        drive(1'b0, 32'd5, 32'd6, taken);
        idle(2);
        drive(1'b1, 32'hFFFF_FFFF, 32'd2, taken);
        wait_result("gap_vector", ok);
        if (ok) begin
            exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
            exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
            checks++; if ({out_sum, out_count, out_ovf} !== exp80) begin errors++; $display("FAIL gap_result: got %h required %h", {out_sum, out_count, out_ovf}, exp80); end
            checks++; if ({out_sum, out_count} !== {80'h2_0000_0028, 16'd3}) begin errors++; $display("FAIL gap_const: got sum %h count %0d required 200000028 count 3", out_sum, out_count); end
            checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL gap_result64: got %h required %h", {out_sum64, out_count64, out_ovf64}, exp64); end
        end
        idle(1);
    endtask

    task automatic test_back_pressure();
        logic t1, t2, t3, ok, seen;
        out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd10, t1);
        drive(1'b1, 32'd20, 32'd20, t2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_falls: got %b required 0", in_ready); end
        drive(1'b1, 32'd30, 32'd30, t3);
        checks++; if ({t1, t2, t3} !== 3'b110) begin errors++; $display("FAIL bp_accept_pattern: got %b required 110", {t1, t2, t3}); end
        idle(6);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled_valid: got %b required 1", out_valid); end
        idle(3);
        checks++; if ({out_sum, out_count, out_ovf} !== q80[0]) begin errors++; $display("FAIL bp_head_stable: got %h required %h", {out_sum, out_count, out_ovf}, q80[0]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b required 0", in_ready); end
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_result("bp_drain", ok);
            if (ok) begin
                exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
                exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
                checks++; if ({out_sum, out_count, out_ovf} !== exp80) begin errors++; $display("FAIL bp_result%0d: got %h required %h", r, {out_sum, out_count, out_ovf}, exp80); end
                checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL bp_result64_%0d: got %h required %h", r, {out_sum64, out_count64, out_ovf64}, exp64); end
            end
            idle(1);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_extra_result: got %b required 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_returns: got %b required 1", in_ready); end
    endtask

    task automatic test_overflow();
        logic taken, ok;
        out_ready = 1'b1;
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, taken);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, taken);
        wait_result("ovf_vector", ok);
        if (ok) begin
            exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
            exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
            checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL ovf_result64: got %h required %h", {out_sum64, out_count64, out_ovf64}, exp64); end
            checks++; if ({out_sum64, out_ovf64} !== {64'hFFFF_FFFC_0000_0002, 1'b1}) begin errors++; $display("FAIL ovf_const64: got sum %h ovf %b required fffffffc00000002 ovf 1", out_sum64, out_ovf64); end
            checks++; if ({out_sum, out_count, out_ovf} !== exp80) begin errors++; $display("FAIL ovf_result80: got %h required %h", {out_sum, out_count, out_ovf}, exp80); end
        end
        idle(1);
        drive(1'b1, 32'd1, 32'd1, taken);
        wait_result("ovf_next", ok);
        if (ok) begin
            exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
            exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
            checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL ovf_next64: got %h required %h", {out_sum64, out_count64, out_ovf64}, exp64); end
            checks++; if (out_ovf64 !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b required 0", out_ovf64); end
        end
        idle(1);
    endtask

    task automatic test_reset_mid_vector();
        logic taken, ok, seen;
        drive(1'b0, 32'd9, 32'd9, taken);
        drive(1'b0, 32'd8, 32'd8, taken);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        q80.delete();
        q64.delete();
        drive(1'b1, 32'd2, 32'd3, taken);
        wait_result("rst_mid", ok);
        if (ok) begin
            exp80 = (q80.size() != 0) ? q80.pop_front() : 'x;
            exp64 = (q64.size() != 0) ? q64.pop_front() : 'x;
            checks++; if ({out_sum, out_count, out_ovf} !== exp80) begin errors++; $display("FAIL rst_mid_result: got %h required %h", {out_sum, out_count, out_ovf}, exp80); end
            checks++; if ({out_sum, out_count} !== {80'd6, 16'd1}) begin errors++; $display("FAIL rst_mid_const: got sum %0d count %0d required 6 count 1", out_sum, out_count); end
            checks++; if ({out_sum64, out_count64, out_ovf64} !== exp64) begin errors++; $display("FAIL rst_mid_result64: got %h required %h", {out_sum64, out_count64, out_ovf64}, exp64); end
        end
        idle(1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_single: got extra result %b required 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_gap_vector();
        test_back_pressure();
        test_overflow();
        test_reset_mid_vector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
